rom_stream_acc: RTL and testbench

ROM_STREAM_ACC -- requirements
Module: rom_stream_acc

---
 rtl/rom_stream_acc.sv | 116 +++++++++++
 tb/tb_rom_stream_acc.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_acc.sv
// Streams NUM_ENTRIES words from an external combinational ROM through a
// valid-tagged register pipeline and sums them into a wrapping or saturating score.
module rom_stream_acc #(
    parameter int DATA_W      = 32,
    parameter int SCORE_W     = 32,
    parameter int ADDR_W      = 8,
    parameter int NUM_ENTRIES = 204,
    parameter int PIPE_STAGES = 3,
    parameter bit SATURATE    = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_data,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] score,
    output logic               overflow,
    output logic [1:0]         dbg_state
);

    // start is a level sampled only in S_IDLE/S_DONE; there is no ready, a run
    // once launched cannot be stalled, only cancelled by rst.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);

    state_t               state, state_nxt;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    stage_data [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] stage_valid;
    logic [SCORE_W-1:0]   score_q;
    logic                 overflow_q;

    logic                 start_ok;
    logic                 last_addr;
    logic                 upstream_valid;
    logic                 acc_en;
    logic                 last_word;
    logic [SCORE_W:0]     sum;

    always_comb begin
        start_ok       = start && (state == S_IDLE || state == S_DONE);
        last_addr      = (addr_q == LAST_ADDR);
        acc_en         = stage_valid[PIPE_STAGES-1];
        upstream_valid = 1'b0;
        for (int i = 0; i < PIPE_STAGES - 1; i++) begin
            upstream_valid = upstream_valid | stage_valid[i];
        end
        // Words enter back to back, so a valid tail with an empty pipe behind it
        // can only be the final word of the run.
        last_word = (state == S_DRAIN) && acc_en && !upstream_valid;
        sum       = {1'b0, score_q} + (SCORE_W + 1)'(stage_data[PIPE_STAGES-1]);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok)  state_nxt = S_RUN;
            S_RUN:   if (last_addr) state_nxt = S_DRAIN;
            S_DRAIN: if (last_word) state_nxt = S_DONE;
            S_DONE:  if (start_ok)  state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            stage_valid <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) stage_data[i] <= '0;
            score_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                addr_q      <= '0;
                stage_valid <= '0;
                for (int i = 0; i < PIPE_STAGES; i++) stage_data[i] <= '0;
                score_q     <= '0;
                overflow_q  <= 1'b0;
            end else begin
                if (state == S_RUN) addr_q <= addr_q + 1'b1;
                stage_valid[0] <= (state == S_RUN);
                stage_data[0]  <= (state == S_RUN) ? rom_data : '0;
                for (int i = 1; i < PIPE_STAGES; i++) begin
                    stage_valid[i] <= stage_valid[i-1];
                    stage_data[i]  <= stage_data[i-1];
                end
                if (acc_en) begin
                    if (sum[SCORE_W]) begin
                        overflow_q <= 1'b1;
                        score_q    <= SATURATE ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
                    end else begin
                        score_q    <= sum[SCORE_W-1:0];
                    end
                end
            end
        end
    end

    assign rom_addr  = (state == S_RUN) ? addr_q : '0;
    assign busy      = (state == S_RUN) || (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign score     = score_q;
    assign overflow  = overflow_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_rom_stream_acc.sv
// Directed bench for rom_stream_acc: small, saturating, wrapping and default
// configurations, with expected scores queued at start and popped at done.
module tb_rom_stream_acc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_s = 1'b0;
    logic start_d = 1'b0;

    always #5 clk = ~clk;

    // 4 entries, 3 stages, rom_data = addr + 1
    logic [7:0]  rom_addr_a;
    logic [31:0] rom_data_a, score_a;
    logic        busy_a, done_a, ovf_a;
    logic [1:0]  st_a;
    // 8-bit score, 4 entries of 100, saturating / wrapping
    logic [7:0]  rom_addr_s, rom_addr_w, rom_data_s, rom_data_w, score_s, score_w;
    logic        busy_s, done_s, ovf_s, busy_w, done_w, ovf_w;
    logic [1:0]  st_s, st_w;
    // defaults, rom_data = 1
    logic [7:0]  rom_addr_d;
    logic [31:0] rom_data_d, score_d;
    logic        busy_d, done_d, ovf_d;
    logic [1:0]  st_d;

    assign rom_data_a = 32'(rom_addr_a) + 32'd1;
    assign rom_data_s = 8'd100;
    assign rom_data_w = 8'd100;
    assign rom_data_d = 32'd1;

    rom_stream_acc #(.DATA_W(32), .SCORE_W(32), .ADDR_W(8), .NUM_ENTRIES(4),
                     .PIPE_STAGES(3), .SATURATE(1'b0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .busy(busy_a), .done(done_a), .score(score_a), .overflow(ovf_a), .dbg_state(st_a));

    rom_stream_acc #(.DATA_W(8), .SCORE_W(8), .ADDR_W(8), .NUM_ENTRIES(4),
                     .PIPE_STAGES(3), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .rom_addr(rom_addr_s), .rom_data(rom_data_s),
        .busy(busy_s), .done(done_s), .score(score_s), .overflow(ovf_s), .dbg_state(st_s));

    rom_stream_acc #(.DATA_W(8), .SCORE_W(8), .ADDR_W(8), .NUM_ENTRIES(4),
                     .PIPE_STAGES(3), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .start(start_s), .rom_addr(rom_addr_w), .rom_data(rom_data_w),
        .busy(busy_w), .done(done_w), .score(score_w), .overflow(ovf_w), .dbg_state(st_w));

    rom_stream_acc dut_d (
        .clk(clk), .rst(rst), .start(start_d), .rom_addr(rom_addr_d), .rom_data(rom_data_d),
        .busy(busy_d), .done(done_d), .score(score_d), .overflow(ovf_d), .dbg_state(st_d));

    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Launch a run on dut_a and follow it to done, re-pulsing start in
    // cycles rp_lo..rp_hi; cycle 0 is the first RUN cycle.
    task automatic run_a(input string tag, input int rp_lo, input int rp_hi);
        int c;
        int busy_cnt;
        c = 0;
        busy_cnt = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check({tag, "_score_cleared"}, score_a, 0);
        check({tag, "_ovf_cleared"}, ovf_a, 0);
        while (!done_a && c < 50) begin
            if (c < 4) check({tag, "_rom_addr"}, rom_addr_a, c);
            if (busy_a) busy_cnt++;
            start_a = (c >= rp_lo && c <= rp_hi);
            @(negedge clk);
            c++;
        end
        start_a = 1'b0;
        check({tag, "_done_cycle"}, c, 7);
        check({tag, "_busy_cycles"}, busy_cnt, 7);
        check({tag, "_busy_low_in_done"}, busy_a, 0);
        check({tag, "_score"}, score_a, exp_q.pop_front());
        check({tag, "_ovf"}, ovf_a, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            assert (!(busy_a && done_a) && !(busy_d && done_d)) else begin
                errors++;
                $error("FAIL busy_done_exclusive: observed both high expected exclusive");
            end
        end
    end

    initial begin
        int c;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_score", score_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_addr", rom_addr_a, 0);
        check("rst_state", st_a, 0);

        // basic run
        exp_q.push_back(32'd10);
        run_a("basic", -1, -1);
        repeat (3) @(negedge clk);
        check("done_hold", done_a, 1);
        check("score_hold", score_a, 10);

        // restart from DONE clears then repeats
        exp_q.push_back(32'd10);
        run_a("restart", -1, -1);

        // start ignored while running
        exp_q.push_back(32'd10);
        run_a("repulse", 1, 3);

        // reset at RUN cycle 2, and later mid-DRAIN with a partial sum
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("rst_run_score", score_a, 0);
        check("rst_run_busy", busy_a, 0);
        check("rst_run_state", st_a, 0);
        exp_q.push_back(32'd10);
        run_a("after_rst2", -1, -1);

        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (5) @(negedge clk);
        check("partial_before_rst", score_a, 3);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("rst_drain_score", score_a, 0);
        check("rst_drain_addr", rom_addr_a, 0);
        exp_q.push_back(32'd10);
        run_a("after_rst5", -1, -1);

        // overflow: saturate and wrap
        exp_q.push_back(32'd255);
        exp_q.push_back(32'd144);
        @(negedge clk); start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        c = 0;
        while (!done_s && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("sat_done_cycle", c, 7);
        check("sat_score", score_s, exp_q.pop_front());
        check("sat_ovf", ovf_s, 1);
        check("wrap_done", done_w, 1);
        check("wrap_score", score_w, exp_q.pop_front());
        check("wrap_ovf", ovf_w, 1);

        // default configuration
        exp_q.push_back(32'd204);
        @(negedge clk); start_d = 1'b1;
        @(negedge clk); start_d = 1'b0;
        c = 0;
        while (!done_d && c < 400) begin
            @(negedge clk);
            c++;
        end
        check("dflt_done_cycle", c, 207);
        check("dflt_score", score_d, exp_q.pop_front());
        check("dflt_ovf", ovf_d, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
